// File: rtl/paddle_pkg.sv
// Shared types and constants for the RC-timing paddle digitizer.
package paddle_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DRAIN,
      MEASURE,
      FILTER,
      APPLY
   } state_t;

   localparam int unsigned DEF_DRAIN_LINES = 4;
   localparam int unsigned DEF_MAX_LINES   = 255;
   localparam int unsigned DEF_RAW_OFFSET  = 8;
   localparam int unsigned DEF_POS_MAX     = 224;
   localparam int unsigned DEF_HYST        = 2;

   localparam int unsigned POS_W = 9;
   localparam int unsigned SUM_W = 11;

   // Offset removal saturating at zero, then clamp to the playfield limit.
   function automatic logic [POS_W-1:0] clamp_adj(input logic [POS_W-1:0] raw,
                                                  input logic [POS_W-1:0] off,
                                                  input logic [POS_W-1:0] pmax);
      logic [POS_W-1:0] d;
      d = (raw > off) ? raw - off : '0;
      return (d > pmax) ? pmax : d;
   endfunction

endpackage

// File: rtl/paddle_filter.sv
// Four-entry moving average with hysteresis on the paddle position output.
module paddle_filter
   import paddle_pkg::*;
#(
   parameter int unsigned POS_MAX = DEF_POS_MAX,
   parameter int unsigned HYST    = DEF_HYST
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [POS_W-1:0] adj,
   input  logic             apply,
   output logic [POS_W-1:0] pos
);

   localparam logic [POS_W-1:0] POS_RST = POS_W'(POS_MAX / 2);
   localparam logic [POS_W-1:0] HYST_V  = POS_W'(HYST);

   logic [POS_W-1:0] hist [4];
   logic [SUM_W-1:0] sum;
   logic             first;
   logic [POS_W-1:0] avg;
   logic [POS_W-1:0] diff;
   logic             upd;

   always_comb begin
      avg  = sum[SUM_W-1:2];
      diff = (avg >= pos) ? avg - pos : pos - avg;
      upd  = first || (diff >= HYST_V);
   end

   // hist[0] is newest, hist[3] oldest; the first sample after reset fills all slots.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < 4; i++) hist[i] <= '0;
         sum   <= '0;
         first <= 1'b1;
         pos   <= POS_RST;
      end else begin
         if (push) begin
            if (first) begin
               for (int unsigned i = 0; i < 4; i++) hist[i] <= adj;
               sum <= {adj, 2'b00};
            end else begin
               hist[0] <= adj;
               for (int unsigned i = 1; i < 4; i++) hist[i] <= hist[i-1];
               sum <= sum + SUM_W'(adj) - SUM_W'(hist[3]);
            end
         end
         if (apply) begin
            if (upd) pos <= avg;
            first <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/paddle_digitizer.sv
// Per-frame RC paddle measurement: drain, count scanlines to threshold, filter.
module paddle_digitizer
   import paddle_pkg::*;
#(
   parameter int unsigned DRAIN_LINES = DEF_DRAIN_LINES,
   parameter int unsigned MAX_LINES   = DEF_MAX_LINES,
   parameter int unsigned RAW_OFFSET  = DEF_RAW_OFFSET,
   parameter int unsigned POS_MAX     = DEF_POS_MAX,
   parameter int unsigned HYST        = DEF_HYST
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       vsync,
   input  logic       hsync,
   input  logic       pdl_in,
   output logic       pdl_drain,
   output logic [8:0] paddle_pos,
   output logic       pos_valid,
   output logic       timeout
);

   localparam logic [POS_W-1:0] DRAIN_LAST = POS_W'(DRAIN_LINES - 1);
   localparam logic [POS_W-1:0] MEAS_LAST  = POS_W'(MAX_LINES - 1);
   localparam logic [POS_W-1:0] MAX_V      = POS_W'(MAX_LINES);
   localparam logic [POS_W-1:0] OFF_V      = POS_W'(RAW_OFFSET);
   localparam logic [POS_W-1:0] PMAX_V     = POS_W'(POS_MAX);

   logic pdl_m, pdl_s;
   logic hsync_d, vsync_d;
   logic line_tick, frame_tick;

   state_t           state, state_nxt;
   logic [POS_W-1:0] line_cnt, cnt_nxt;
   logic [POS_W-1:0] raw, raw_nxt;
   logic             to_flag, to_nxt;
   logic [POS_W-1:0] adj;
   logic             push, apply;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pdl_m   <= 1'b0;
         pdl_s   <= 1'b0;
         hsync_d <= 1'b0;
         vsync_d <= 1'b0;
      end else begin
         pdl_m   <= pdl_in;
         pdl_s   <= pdl_m;
         hsync_d <= hsync;
         vsync_d <= vsync;
      end
   end

   assign line_tick  = hsync & ~hsync_d;
   assign frame_tick = vsync & ~vsync_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         line_cnt <= '0;
         raw      <= '0;
         to_flag  <= 1'b0;
      end else begin
         state    <= state_nxt;
         line_cnt <= cnt_nxt;
         raw      <= raw_nxt;
         to_flag  <= to_nxt;
      end
   end

   // frame_tick is tested before line_tick so it wins a same-cycle collision.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = line_cnt;
      raw_nxt   = raw;
      to_nxt    = to_flag;
      unique case (state)
         IDLE: begin
            if (frame_tick) begin
               state_nxt = DRAIN;
               cnt_nxt   = '0;
               to_nxt    = 1'b0;
            end
         end
         DRAIN: begin
            if (frame_tick) begin
               cnt_nxt = '0;
               to_nxt  = 1'b0;
            end else if (line_tick) begin
               if (line_cnt == DRAIN_LAST) begin
                  state_nxt = MEASURE;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = line_cnt + 1'b1;
               end
            end
         end
         MEASURE: begin
            if (frame_tick) begin
               state_nxt = DRAIN;
               cnt_nxt   = '0;
               to_nxt    = 1'b0;
            end else if (line_tick) begin
               if (pdl_s) begin
                  raw_nxt   = line_cnt;
                  state_nxt = FILTER;
               end else if (line_cnt == MEAS_LAST) begin
                  raw_nxt   = MAX_V;
                  to_nxt    = 1'b1;
                  state_nxt = FILTER;
               end else begin
                  cnt_nxt = line_cnt + 1'b1;
               end
            end
         end
         FILTER:  state_nxt = APPLY;
         APPLY:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign adj   = clamp_adj(raw, OFF_V, PMAX_V);
   assign push  = (state == FILTER);
   assign apply = (state == APPLY);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pdl_drain <= 1'b0;
         pos_valid <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         pdl_drain <= (state_nxt == DRAIN);
         pos_valid <= apply;
         if (apply) timeout <= to_flag;
      end
   end

   paddle_filter #(
      .POS_MAX(POS_MAX),
      .HYST   (HYST)
   ) u_filter (
      .clk  (clk),
      .reset(reset),
      .push (push),
      .adj  (adj),
      .apply(apply),
      .pos  (paddle_pos)
   );

endmodule

// File: tb/tb_paddle_digitizer.sv
// Directed bench for paddle_digitizer with hand-computed positions.
module tb_paddle_digitizer;

   logic       clk = 1'b0;
   logic       reset;
   logic       vsync;
   logic       hsync;
   logic       pdl_in;
   logic       pdl_drain;
   logic [8:0] paddle_pos;
   logic       pos_valid;
   logic       timeout;

   int checks   = 0;
   int failures = 0;
   int pv_count = 0;
   int pv_a;

   always #5 clk = ~clk;

   always @(posedge clk) if (pos_valid === 1'b1) pv_count <= pv_count + 1;

   paddle_digitizer #(
      .DRAIN_LINES(4),
      .MAX_LINES  (255),
      .RAW_OFFSET (8),
      .POS_MAX    (224),
      .HYST       (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .vsync     (vsync),
      .hsync     (hsync),
      .pdl_in    (pdl_in),
      .pdl_drain (pdl_drain),
      .paddle_pos(paddle_pos),
      .pos_valid (pos_valid),
      .timeout   (timeout)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic tick();
      hsync = 1'b1;
      cyc(1);
      hsync = 1'b0;
   endtask

   task automatic start_drain(input string tag);
      pdl_in = 1'b0;
      vsync  = 1'b1;
      cyc(1);
      chk({tag, ".drain_rise"}, 32'(pdl_drain), 32'd1);
      cyc(1);
      vsync = 1'b0;
      for (int d = 0; d < 4; d++) begin
         cyc(11);
         tick();
         chk({tag, ".drain_line"}, 32'(pdl_drain), (d < 3) ? 32'd1 : 32'd0);
      end
   endtask

   // Full frame; pdl_in rises before measure line n (late: only 1 cycle before it).
   task automatic frame(input string tag, input int n, input bit late,
                        input int exp_pos, input bit exp_to);
      int cap;
      int pv0;
      cap = late ? n + 1 : n;
      if (cap > 254) cap = 254;
      start_drain(tag);
      pv0 = pv_count;
      for (int i = 0; i <= cap; i++) begin
         if (i == n && late) begin
            cyc(10);
            pdl_in = 1'b1;
            cyc(1);
         end else begin
            if (i == n) pdl_in = 1'b1;
            cyc(11);
         end
         tick();
      end
      pdl_in = 1'b0;
      cyc(1);
      chk({tag, ".pv_early"}, 32'(pos_valid), 32'd0);
      cyc(1);
      chk({tag, ".pv"}, 32'(pos_valid), 32'd1);
      chk({tag, ".pos"}, 32'(paddle_pos), 32'(exp_pos));
      chk({tag, ".timeout"}, 32'(timeout), 32'(exp_to));
      cyc(1);
      chk({tag, ".pv_drop"}, 32'(pos_valid), 32'd0);
      chk({tag, ".pv_count"}, 32'(pv_count), 32'(pv0 + 1));
      cyc(5);
   endtask

   initial begin
      reset  = 1'b0;
      vsync  = 1'b0;
      hsync  = 1'b0;
      pdl_in = 1'b0;
      cyc(3);
      chk("rst.pos", 32'(paddle_pos), 32'd112);
      chk("rst.pv", 32'(pos_valid), 32'd0);
      chk("rst.drain", 32'(pdl_drain), 32'd0);
      chk("rst.timeout", 32'(timeout), 32'd0);
      reset = 1'b1;
      cyc(5);

      // raw 50 -> adj 42 primes history; then averaging and hysteresis
      frame("A", 50, 1'b0, 42, 1'b0);
      frame("B", 50, 1'b0, 42, 1'b0);
      frame("C", 58, 1'b0, 44, 1'b0);
      frame("D", 51, 1'b0, 44, 1'b0);

      // Abort at measure line 30, then a frame whose average exposes any stray push
      pv_a = pv_count;
      start_drain("AB");
      for (int i = 0; i < 30; i++) begin
         cyc(11);
         tick();
      end
      cyc(3);
      chk("AB.no_pv", 32'(pv_count), 32'(pv_a));
      frame("E", 66, 1'b0, 48, 1'b0);
      chk("AB.no_pv_total", 32'(pv_count), 32'(pv_a + 1));

      // Reset during DRAIN
      vsync = 1'b1;
      cyc(2);
      vsync = 1'b0;
      for (int d = 0; d < 2; d++) begin
         cyc(11);
         tick();
      end
      cyc(3);
      chk("MR.drain_before", 32'(pdl_drain), 32'd1);
      reset = 1'b0;
      #1;
      chk("MR.drain", 32'(pdl_drain), 32'd0);
      chk("MR.pos", 32'(paddle_pos), 32'd112);
      cyc(2);
      reset = 1'b1;
      cyc(5);

      // Timeout primes to clamp limit; held until the next completion
      frame("TO", 1000, 1'b0, 224, 1'b1);
      cyc(20);
      chk("TO.held", 32'(timeout), 32'd1);
      frame("F", 0, 1'b0, 168, 1'b0);

      reset = 1'b0;
      cyc(2);
      reset = 1'b1;
      cyc(3);
      frame("G", 0, 1'b0, 0, 1'b0);

      // pdl_in rising 1 cycle before line 23 is captured at line 24 (adj 16, avg 4)
      frame("H", 23, 1'b1, 4, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
